ab_pattern_sequencer: RTL and testbench

//  Drives the 2-bit a / 2-bit b operand inputs of the RGB colour-decode logic.

---
 rtl/ab_pattern_sequencer.sv | 140 ++++++++++++++
 tb/tb_ab_pattern_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ab_pattern_sequencer.sv
// ab_pattern_sequencer: steps the colour-decode operands {a,b} through all 16
// codes, holding each for HOLD_CYCLES clocks, with start/pause button control.
module ab_pattern_sequencer #(
  parameter int unsigned HOLD_CYCLES = 100_000_000,
  parameter bit          LOOP        = 1'b0,
  parameter int unsigned CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       pause_btn,
  output logic [1:0] a,
  output logic [1:0] b,
  output logic [3:0] index,
  output logic       busy,
  output logic       done
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       r_index;
  logic [3:0]       w_index_nxt;
  logic [1:0]       r_a;
  logic [1:0]       r_b;
  logic             r_start_q;
  logic             r_pause_q;
  logic             w_start_rise;
  logic             w_pause_rise;
  logic             w_tc;
  logic             w_last;

  assign w_start_rise = start_btn & ~r_start_q;
  assign w_pause_rise = pause_btn & ~r_pause_q;
  assign w_tc         = (r_cnt == TC_VAL);
  assign w_last       = (r_index == 4'd15);

  assign a     = r_a;
  assign b     = r_b;
  assign index = r_index;

  // Button history; resets high so a button held through reset gives no edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_start_q <= 1'b1;
      r_pause_q <= 1'b1;
    end else begin
      r_start_q <= start_btn;
      r_pause_q <= pause_btn;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Hold counter, code index and operand registers; {a,b} tracks index exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_index <= '0;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_index <= w_index_nxt;
      r_a     <= w_index_nxt[3:2];
      r_b     <= w_index_nxt[1:0];
    end
  end

  // Next-state and next counter/index; pause beats terminal count and start in RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_index_nxt = r_index;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start_rise) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
          w_index_nxt = '0;
        end
      end
      S_RUN: begin
        if (w_pause_rise) begin
          w_state_nxt = S_PAUSED;
        end else if (w_tc) begin
          w_cnt_nxt = '0;
          if (w_last) begin
            if (LOOP) begin
              w_index_nxt = '0;
            end else begin
              w_state_nxt = S_DONE;
            end
          end else begin
            w_index_nxt = r_index + 4'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_PAUSED: begin
        if (w_start_rise || w_pause_rise) begin
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Status decode from the registered state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_RUN, S_PAUSED: busy = 1'b1;
      S_DONE:          done = 1'b1;
      default:         ;
    endcase
  end

endmodule

// File: tb/tb_ab_pattern_sequencer.sv
// Bench for ab_pattern_sequencer: three instances (hold 4 / no loop, hold 4 / loop,
// hold 1 / no loop); expected per-cycle outputs are queued as stimulus is applied.
module tb_ab_pattern_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0 = 1'b1, st0 = 1'b0, pa0 = 1'b0;
  logic       rst1 = 1'b1, st1 = 1'b0, pa1 = 1'b0;
  logic       rst2 = 1'b1, st2 = 1'b0, pa2 = 1'b0;
  logic [1:0] a0, b0, a1, b1, a2, b2;
  logic [3:0] idx0, idx1, idx2;
  logic       busy0, busy1, busy2, done0, done1, done2;

  ab_pattern_sequencer #(.HOLD_CYCLES(4), .LOOP(1'b0)) u0 (
    .clk(clk), .reset(rst0), .start_btn(st0), .pause_btn(pa0),
    .a(a0), .b(b0), .index(idx0), .busy(busy0), .done(done0));

  ab_pattern_sequencer #(.HOLD_CYCLES(4), .LOOP(1'b1)) u1 (
    .clk(clk), .reset(rst1), .start_btn(st1), .pause_btn(pa1),
    .a(a1), .b(b1), .index(idx1), .busy(busy1), .done(done1));

  ab_pattern_sequencer #(.HOLD_CYCLES(1), .LOOP(1'b0)) u2 (
    .clk(clk), .reset(rst2), .start_btn(st2), .pause_btn(pa2),
    .a(a2), .b(b2), .index(idx2), .busy(busy2), .done(done2));

  typedef struct {
    int idx;
    int busy;
    int done;
  } exp_t;

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [7:0] got, input int exp);
    n_checks++;
    if (got !== 8'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input int n, input int idx, input int bz, input int dn);
    exp_t e;
    e.idx  = idx;
    e.busy = bz;
    e.done = dn;
    for (int i = 0; i < n; i++) q_exp.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pop one expected entry and compare it against the selected instance now.
  task automatic compare(input int sel);
    exp_t       e;
    logic [7:0] oi, oab, ob, od;
    if (q_exp.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_underflow: got empty queue expected entry");
      return;
    end
    e = q_exp.pop_front();
    case (sel)
      0:       begin oi = 8'(idx0); oab = 8'({a0, b0}); ob = 8'(busy0); od = 8'(done0); end
      1:       begin oi = 8'(idx1); oab = 8'({a1, b1}); ob = 8'(busy1); od = 8'(done1); end
      default: begin oi = 8'(idx2); oab = 8'({a2, b2}); ob = 8'(busy2); od = 8'(done2); end
    endcase
    check_eq($sformatf("u%0d_index", sel), oi, e.idx);
    check_eq($sformatf("u%0d_ab", sel), oab, e.idx);
    check_eq($sformatf("u%0d_busy", sel), ob, e.busy);
    check_eq($sformatf("u%0d_done", sel), od, e.done);
  endtask

  task automatic step(input int sel);
    tick();
    compare(sel);
  endtask

  task automatic drain(input int sel);
    while (q_exp.size() > 0) step(sel);
  endtask

  task automatic push_codes(input int first, input int last, input int hold);
    for (int c = first; c <= last; c++) push_exp(hold, c, 1, 0);
  endtask

  initial begin
    // Reset values while reset is held.
    #1;
    push_exp(1, 0, 0, 0);
    compare(0);
    tick();
    rst0 = 1'b0;
    rst1 = 1'b0;
    push_exp(2, 0, 0, 0);
    drain(0);

    // Full non-looping sweep, 4 cycles per code, ending in DONE at code 15.
    st0 = 1'b1;
    push_codes(0, 15, 4);
    step(0);
    st0 = 1'b0;
    drain(0);
    push_exp(3, 15, 0, 1);
    drain(0);

    // Restart from DONE, pause with the counter at 2 inside code 5.
    st0 = 1'b1;
    push_codes(0, 4, 4);
    push_exp(3, 5, 1, 0);
    step(0);
    st0 = 1'b0;
    drain(0);
    pa0 = 1'b1;
    push_exp(10, 5, 1, 0);
    step(0);
    pa0 = 1'b0;
    drain(0);
    // Resume: code 5 runs two more cycles.
    pa0 = 1'b1;
    push_exp(2, 5, 1, 0);
    push_exp(4, 6, 1, 0);
    push_exp(1, 7, 1, 0);
    step(0);
    pa0 = 1'b0;
    drain(0);

    // Start and pause rising together in RUN: pause wins, no restart.
    st0 = 1'b1;
    pa0 = 1'b1;
    push_exp(5, 7, 1, 0);
    step(0);
    st0 = 1'b0;
    pa0 = 1'b0;
    drain(0);
    // Resume via start; counter frozen at 0 so code 7 gets a full hold.
    st0 = 1'b1;
    push_exp(4, 7, 1, 0);
    push_exp(1, 8, 1, 0);
    step(0);
    st0 = 1'b0;
    drain(0);

    // Asynchronous reset mid-run, checked before the next clock edge.
    #2;
    rst0 = 1'b1;
    #1;
    push_exp(1, 0, 0, 0);
    compare(0);
    tick();
    rst0 = 1'b0;
    push_exp(3, 0, 0, 0);
    drain(0);

    // Looping instance: code 15 held 4 cycles then wraps to 0 still busy.
    st1 = 1'b1;
    push_codes(0, 15, 4);
    push_exp(4, 0, 1, 0);
    push_exp(1, 1, 1, 0);
    step(1);
    st1 = 1'b0;
    drain(1);

    // Hold of 1, start held high through reset release: no start.
    st2 = 1'b1;
    tick();
    rst2 = 1'b0;
    push_exp(5, 0, 0, 0);
    drain(2);
    st2 = 1'b0;
    push_exp(1, 0, 0, 0);
    step(2);
    st2 = 1'b1;
    push_codes(0, 15, 1);
    push_exp(2, 15, 0, 1);
    step(2);
    st2 = 1'b0;
    drain(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
